// File: rtl/multi_booth_param.sv
// Sequential radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned per operation.
// Latency: N_ITER+1 cycles from accept to valid; variable (2..N_ITER+1) with MULTI_EARLY_EXIT_EN defined.
// No backpressure: start edges while busy are dropped, valid is a one-cycle pulse, prodt holds until next result.
module multi_booth_param #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   mlier,
  input  logic [WIDTH-1:0]   mcand,
  input  logic               tc,
  input  logic               start,
  output logic [2*WIDTH-1:0] prodt,
  output logic               valid,
  output logic               busy
);

  localparam int N_ITER = WIDTH / 2 + 1;
  localparam int PW     = 2 * WIDTH;
  localparam int MW     = WIDTH + 3;
  localparam int CW     = $clog2(N_ITER + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic            start_q;
  logic [MW-1:0]   mreg_q;
  logic [PW-1:0]   mc_q;
  logic [PW-1:0]   acc_q;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   prodt_q;
  logic            valid_q;
  logic            busy_q;

  logic            accept;
  logic            ext_m;
  logic [MW-1:0]   mreg_init;
  logic [PW-1:0]   mc_init;
  logic [PW-1:0]   mc2;
  logic [PW-1:0]   addend;
  logic [PW-1:0]   acc_d;
  logic [PW-1:0]   mc_d;
  logic [MW-1:0]   mreg_d;
  logic            last_digit;
  logic            all_eq;

  // busy_q is still high during the valid cycle, which keeps a new accept out until the cycle after valid.
  assign accept     = start & ~start_q & (state_q == IDLE) & ~busy_q;
  assign ext_m      = tc & mlier[WIDTH-1];
  assign mreg_init  = {ext_m, ext_m, mlier, 1'b0};
  assign mc_init    = {{WIDTH{tc & mcand[WIDTH-1]}}, mcand};
  assign mc2        = {mc_q[PW-2:0], 1'b0};
  assign mc_d       = {mc_q[PW-3:0], 2'b00};
  assign mreg_d     = {{2{mreg_q[MW-1]}}, mreg_q[MW-1:2]};
  assign acc_d      = acc_q + addend;
  assign last_digit = (cnt_q == CW'(N_ITER - 1));

`ifdef MULTI_EARLY_EXIT_EN
  // Once the remaining multiplier bits are all equal every further Booth digit is zero.
  assign all_eq = (&mreg_q) | ~(|mreg_q);
`else
  assign all_eq = 1'b0;
`endif

  // Booth digit decode from the low three bits of the shifting multiplier.
  always_comb begin
    addend = '0;
    case (mreg_q[2:0])
      3'b001, 3'b010: addend = mc_q;
      3'b011:         addend = mc2;
      3'b100:         addend = -mc2;
      3'b101, 3'b110: addend = -mc_q;
      default:        addend = '0;
    endcase
  end

  // Control FSM and datapath registers; all sums wrap modulo 2^(2*WIDTH).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      mreg_q  <= '0;
      mc_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      prodt_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      start_q <= start;
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q <= accept;
          if (accept) begin
            mreg_q  <= mreg_init;
            mc_q    <= mc_init;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (all_eq) begin
            state_q <= DONE;
          end else begin
            acc_q  <= acc_d;
            mc_q   <= mc_d;
            mreg_q <= mreg_d;
            cnt_q  <= cnt_q + CW'(1);
            if (last_digit) state_q <= DONE;
          end
        end
        DONE: begin
          prodt_q <= acc_q;
          valid_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign prodt = prodt_q;
  assign valid = valid_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_multi_booth_param.sv
// Directed-vector bench for multi_booth_param at WIDTH=32.
// Expected products and latencies are hand-computed; latency column follows MULTI_EARLY_EXIT_EN.
// Start is driven on the falling edge, outputs are sampled on the falling edge.
module tb_multi_booth_param;

  localparam int W = 32;
`ifdef MULTI_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           reset_n;
  logic [W-1:0]   mlier;
  logic [W-1:0]   mcand;
  logic           tc;
  logic           start;
  logic [2*W-1:0] prodt;
  logic           valid;
  logic           busy;

  int n_chk  = 0;
  int n_pass = 0;

  multi_booth_param #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .mlier   (mlier),
    .mcand   (mcand),
    .tc      (tc),
    .start   (start),
    .prodt   (prodt),
    .valid   (valid),
    .busy    (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%h, expected 0x%h", tag, obs, exp);
  endtask

  // One operation: start held high until valid; optional second start edge while busy.
  task automatic run_op(input string tag, input logic t, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_p, input int exp_lat, input bit glitch);
    int  lat;
    int  busy_low;
    int  extra;
    bit  found;
    lat = 0;
    busy_low = 0;
    extra = 0;
    found = 1'b0;
    @(negedge clock);
    tc = t; mlier = a; mcand = b; start = 1'b1;
    @(posedge clock);
    for (int k = 0; k <= 33; k++) begin
      @(negedge clock);
      if (glitch && k == 2) start = 1'b0;
      if (glitch && k == 5) start = 1'b1;
      if (!busy) busy_low++;
      if (valid) begin
        lat = k;
        found = 1'b1;
        break;
      end
    end
    chk({tag, "_valid_seen"}, 64'(found), 64'd1);
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_prodt"}, prodt, exp_p);
    chk({tag, "_busy_held"}, 64'(busy_low), 64'd0);
    start = 1'b0;
    @(negedge clock);
    chk({tag, "_valid_pulse"}, 64'(valid), 64'd0);
    chk({tag, "_busy_clear"}, 64'(busy), 64'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (valid) extra++;
    end
    chk({tag, "_no_extra_valid"}, 64'(extra), 64'd0);
    chk({tag, "_prodt_held"}, prodt, exp_p);
  endtask

  initial begin
    int late;
    reset_n = 1'b0;
    start = 1'b0;
    tc = 1'b0;
    mlier = '0;
    mcand = '0;
    repeat (3) @(negedge clock);
    chk("reset_prodt", prodt, 64'd0);
    chk("reset_valid", 64'(valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    run_op("t1",      1'b1, 32'h5555_5555, 32'h0000_0001, 64'h0000_0000_5555_5555, 18, 1'b0);
    run_op("t2_min",  1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 18, 1'b0);
    run_op("t2_neg1", 1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 64'h0000_0000_8000_0000, EE ? 3 : 18, 1'b0);
    run_op("t3_uns",  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 18, 1'b0);
    run_op("t3_sgn",  1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, EE ? 3 : 18, 1'b0);
    run_op("uns_msb", 1'b0, 32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000, 18, 1'b0);
    run_op("sgn_neg", 1'b1, 32'h0000_0003, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA, EE ? 4 : 18, 1'b0);
    run_op("t4",      1'b0, 32'h0000_1234, 32'h0000_0010, 64'h0000_0000_0001_2340, EE ? 9 : 18, 1'b1);

    // Reset in the middle of an operation.
    @(negedge clock);
    tc = 1'b1; mlier = 32'h5555_5555; mcand = 32'h0000_0003; start = 1'b1;
    @(posedge clock);
    repeat (8) @(negedge clock);
    chk("t5_busy_before_reset", 64'(busy), 64'd1);
    reset_n = 1'b0;
    start = 1'b0;
    #1;
    chk("t5_reset_prodt", prodt, 64'd0);
    chk("t5_reset_valid", 64'(valid), 64'd0);
    chk("t5_reset_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    late = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (valid) late++;
    end
    chk("t5_no_late_valid", 64'(late), 64'd0);
    run_op("t5_next", 1'b1, 32'h0000_0001, 32'h7FFF_FFFF, 64'h0000_0000_7FFF_FFFF, EE ? 3 : 18, 1'b0);

    run_op("t6_zero", 1'b1, 32'h0000_0000, 32'h1234_5678, 64'h0000_0000_0000_0000, EE ? 2 : 18, 1'b0);
    run_op("t6_m1",   1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, EE ? 3 : 18, 1'b0);
    run_op("t6_max",  1'b1, 32'h7FFF_FFFF, 32'h0000_0003, 64'h0000_0001_7FFF_FFFD, 18, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
